// File: rtl/atconv_pkg.sv
// Shared widths, default memory depths and controller states for the atrous-conv host.
// Imported by the host and its RAM sub-module.
package atconv_pkg;
    localparam int DW            = 13;
    localparam int AW            = 12;
    localparam int IMG_WORDS_DEF = 4096;
    localparam int L1_WORDS_DEF  = 1024;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        READY,
        RUN,
        DUMP,
        DONE
    } state_t;
endpackage

// File: rtl/atconv_ram.sv
// Simple RAM: one synchronous write port, two zero-latency asynchronous read ports.
// No flow control; contents are never reset, so they survive controller resets.
module atconv_ram #(
    parameter int DEPTH = 4096,
    parameter int AW    = 12,
    parameter int DW    = 13
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr_a,
    output logic [DW-1:0] rdata_a,
    input  logic [AW-1:0] raddr_b,
    output logic [DW-1:0] rdata_b
);
    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // Reads see pre-write contents during a same-cycle write.
    assign rdata_a = mem[raddr_a];
    assign rdata_b = mem[raddr_b];
endmodule

// File: rtl/atconv_host.sv
// Host buffer for the atrous-conv engine: streams an image in, serves engine ports, dumps both layers.
// Memory reads are zero-latency; load stalls on in_valid, dump entries hold until out_ready.
module atconv_host
    import atconv_pkg::*;
#(
    parameter int IMG_WORDS = IMG_WORDS_DEF,
    parameter int L1_WORDS  = L1_WORDS_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          ready,
    input  logic          busy,
    input  logic [AW-1:0] iaddr,
    output logic [DW-1:0] idata,
    input  logic          cwr,
    input  logic [AW-1:0] caddr_wr,
    input  logic [DW-1:0] cdata_wr,
    input  logic          crd,
    input  logic [AW-1:0] caddr_rd,
    output logic [DW-1:0] cdata_rd,
    input  logic          csel,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          out_sel,
    output logic [AW-1:0] out_addr,
    output logic          done,
    output logic          err
);
    localparam int            IMG_AW   = $clog2(IMG_WORDS);
    localparam int            L1_AW    = $clog2(L1_WORDS);
    localparam logic [AW-1:0] IMG_LAST = AW'(IMG_WORDS - 1);
    localparam logic [AW-1:0] L1_LAST  = AW'(L1_WORDS - 1);

    state_t        state, state_nxt;
    logic [AW-1:0] cnt, cnt_nxt;
    logic          sel, sel_nxt;
    logic          busy_q;
    logic          img_we, l0_we, l1_we;
    logic          l1_wr_ok, l1_rd_ok, err_set;
    logic [DW-1:0] l0_rd, l1_rd, l0_dump, l1_dump, img_rd_unused;

    // 32-bit compares so a full-range layer 1 depth cannot alias to zero.
    assign l1_wr_ok = 32'(caddr_wr) < L1_WORDS;
    assign l1_rd_ok = 32'(caddr_rd) < L1_WORDS;

    assign l0_we   = cwr && (state == RUN) && !csel;
    assign l1_we   = cwr && (state == RUN) && csel && l1_wr_ok;
    assign err_set = csel && ((cwr && (state == RUN) && !l1_wr_ok) || (crd && !l1_rd_ok));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            cnt    <= '0;
            sel    <= 1'b0;
            busy_q <= 1'b0;
            err    <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            sel    <= sel_nxt;
            busy_q <= busy;
            if (err_set) err <= 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        sel_nxt   = sel;
        in_ready  = 1'b0;
        ready     = 1'b0;
        out_valid = 1'b0;
        done      = 1'b0;
        img_we    = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    img_we    = 1'b1;
                    cnt_nxt   = AW'(1);
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    img_we = 1'b1;
                    if (cnt == IMG_LAST) begin
                        cnt_nxt   = '0;
                        state_nxt = READY;
                    end else begin
                        cnt_nxt = cnt + AW'(1);
                    end
                end
            end
            READY: begin
                ready = 1'b1;
                if (busy) state_nxt = RUN;
            end
            RUN: begin
                if (busy_q && !busy) begin
                    cnt_nxt   = '0;
                    sel_nxt   = 1'b0;
                    state_nxt = DUMP;
                end
            end
            DUMP: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    if (!sel && (cnt == IMG_LAST)) begin
                        cnt_nxt = '0;
                        sel_nxt = 1'b1;
                    end else if (sel && (cnt == L1_LAST)) begin
                        cnt_nxt   = '0;
                        sel_nxt   = 1'b0;
                        state_nxt = DONE;
                    end else begin
                        cnt_nxt = cnt + AW'(1);
                    end
                end
            end
            DONE: begin
                done      = 1'b1;
                cnt_nxt   = '0;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    atconv_ram #(.DEPTH(IMG_WORDS), .AW(IMG_AW), .DW(DW)) u_img (
        .clk     (clk),
        .we      (img_we),
        .waddr   (cnt[IMG_AW-1:0]),
        .wdata   (in_data),
        .raddr_a (iaddr[IMG_AW-1:0]),
        .rdata_a (idata),
        .raddr_b (iaddr[IMG_AW-1:0]),
        .rdata_b (img_rd_unused)
    );

    atconv_ram #(.DEPTH(IMG_WORDS), .AW(IMG_AW), .DW(DW)) u_l0 (
        .clk     (clk),
        .we      (l0_we),
        .waddr   (caddr_wr[IMG_AW-1:0]),
        .wdata   (cdata_wr),
        .raddr_a (caddr_rd[IMG_AW-1:0]),
        .rdata_a (l0_rd),
        .raddr_b (cnt[IMG_AW-1:0]),
        .rdata_b (l0_dump)
    );

    atconv_ram #(.DEPTH(L1_WORDS), .AW(L1_AW), .DW(DW)) u_l1 (
        .clk     (clk),
        .we      (l1_we),
        .waddr   (caddr_wr[L1_AW-1:0]),
        .wdata   (cdata_wr),
        .raddr_a (caddr_rd[L1_AW-1:0]),
        .rdata_a (l1_rd),
        .raddr_b (cnt[L1_AW-1:0]),
        .rdata_b (l1_dump)
    );

    always_comb begin
        cdata_rd = '0;
        if (crd) begin
            if (!csel)         cdata_rd = l0_rd;
            else if (l1_rd_ok) cdata_rd = l1_rd;
        end
    end

    assign out_data = sel ? l1_dump : l0_dump;
    assign out_sel  = sel;
    assign out_addr = cnt;
endmodule

// File: tb/tb_atconv_host.sv
// Self-checking bench for atconv_host: table vectors for port behaviour, random traffic
// against array models of image/layer memories, and hand sequences for dump and reset aborts.
module tb_atconv_host;
    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready, ready, busy;
    logic [12:0] in_data, idata, cdata_wr, cdata_rd, out_data;
    logic [11:0] iaddr, caddr_wr, caddr_rd, out_addr;
    logic        cwr, crd, csel, out_valid, out_ready, out_sel, done, err;

    int checks = 0;
    int errors = 0;

    logic [12:0] img_m [4096];
    logic [12:0] l0_m  [4096];
    logic [12:0] l1_m  [1024];

    typedef struct {
        logic [11:0] addr;
        logic [12:0] exp;
    } ivec_t;

    typedef struct {
        logic        wr;
        logic        rd;
        logic        sel;
        logic [11:0] waddr;
        logic [12:0] wdata;
        logic [11:0] raddr;
        logic [12:0] exp_rd;
        logic        exp_err;
    } cvec_t;

    atconv_host dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .ready     (ready),
        .busy      (busy),
        .iaddr     (iaddr),
        .idata     (idata),
        .cwr       (cwr),
        .caddr_wr  (caddr_wr),
        .cdata_wr  (cdata_wr),
        .crd       (crd),
        .caddr_rd  (caddr_rd),
        .cdata_rd  (cdata_rd),
        .csel      (csel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_addr  (out_addr),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_image(input bit ramp, output int bad);
        bad = 0;
        for (int i = 0; i < 4096; i++) begin
            in_valid = 1'b1;
            in_data  = ramp ? 13'(i) : 13'($urandom);
            busy     = ramp && (i >= 1000) && (i < 1010);
            img_m[i] = in_data;
            @(negedge clk);
            if (ready !== 1'b0 || in_ready !== 1'b1) bad++;
            step();
        end
        in_valid = 1'b0;
        busy     = 1'b0;
    endtask

    initial begin
        ivec_t itab [4];
        cvec_t ctab [10];
        int    bad, hs, done_cnt, bad_data, bad_stable, tail;
        logic  stall_pending, sel4097, hit;
        logic [11:0] addr4097, ra, wa;
        logic [25:0] held;
        logic [12:0] exp_d;
        logic        s, w, r;

        itab[0] = '{12'h000, 13'h0000};
        itab[1] = '{12'h123, 13'h0123};
        itab[2] = '{12'h7FF, 13'h07FF};
        itab[3] = '{12'hFFF, 13'h0FFF};

        //          wr    rd    sel   waddr    wdata     raddr    exp_rd    exp_err
        ctab[0] = '{1'b1, 1'b0, 1'b1, 12'h000, 13'h0222, 12'h000, 13'h0000, 1'b0};
        ctab[1] = '{1'b1, 1'b1, 1'b1, 12'h005, 13'h0111, 12'h000, 13'h0222, 1'b0};
        ctab[2] = '{1'b1, 1'b1, 1'b1, 12'h005, 13'h1ABC, 12'h005, 13'h0111, 1'b0};
        ctab[3] = '{1'b0, 1'b1, 1'b1, 12'h000, 13'h0000, 12'h005, 13'h1ABC, 1'b0};
        ctab[4] = '{1'b1, 1'b0, 1'b0, 12'h005, 13'h0F0F, 12'h005, 13'h0000, 1'b0};
        ctab[5] = '{1'b0, 1'b1, 1'b0, 12'h000, 13'h0000, 12'h005, 13'h0F0F, 1'b0};
        ctab[6] = '{1'b1, 1'b1, 1'b1, 12'h400, 13'h1FFF, 12'h005, 13'h1ABC, 1'b0};
        ctab[7] = '{1'b0, 1'b1, 1'b1, 12'h000, 13'h0000, 12'h000, 13'h0222, 1'b1};
        ctab[8] = '{1'b0, 1'b1, 1'b1, 12'h000, 13'h0000, 12'h400, 13'h0000, 1'b1};
        ctab[9] = '{1'b0, 1'b0, 1'b0, 12'h000, 13'h0000, 12'h005, 13'h0000, 1'b1};

        reset = 1'b0; in_valid = 1'b0; in_data = '0; busy = 1'b0; iaddr = '0;
        cwr = 1'b0; caddr_wr = '0; cdata_wr = '0; crd = 1'b0; caddr_rd = '0; csel = 1'b0;
        out_ready = 1'b0;

        #12;
        chk("rst_ready", ready, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_err", err, 1'b0);
        #10 reset = 1'b1;
        step();
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1'b1);
        step();

        // Ramp load with a busy pulse mid-load that must be ignored.
        load_image(1'b1, bad);
        chk("load_ready_low_in_ready_high", bad, 0);
        @(negedge clk);
        chk("ready_after_4096", ready, 1'b1);
        chk("in_ready_after_load", in_ready, 1'b0);

        foreach (itab[k]) begin
            iaddr = itab[k].addr;
            @(negedge clk);
            chk("idata_table", {19'd0, idata}, {19'd0, itab[k].exp});
        end
        chk("ready_held", ready, 1'b1);

        busy = 1'b1;
        step();
        @(negedge clk);
        chk("ready_low_in_run", ready, 1'b0);
        step();

        foreach (ctab[k]) begin
            cwr = ctab[k].wr; crd = ctab[k].rd; csel = ctab[k].sel;
            caddr_wr = ctab[k].waddr; cdata_wr = ctab[k].wdata; caddr_rd = ctab[k].raddr;
            @(negedge clk);
            chk("layer_table_rd", cdata_rd, ctab[k].exp_rd);
            chk("layer_table_err", err, ctab[k].exp_err);
            step();
        end

        // Give every layer word a known random value, then mix random reads and writes.
        crd = 1'b0; cwr = 1'b1;
        for (int a = 0; a < 4096; a++) begin
            csel = 1'b0; caddr_wr = 12'(a); cdata_wr = 13'($urandom); l0_m[a] = cdata_wr;
            step();
        end
        for (int a = 0; a < 1024; a++) begin
            csel = 1'b1; caddr_wr = 12'(a); cdata_wr = 13'($urandom); l1_m[a] = cdata_wr;
            step();
        end
        for (int n = 0; n < 400; n++) begin
            s = 1'($urandom_range(0, 1));
            w = 1'($urandom_range(0, 1));
            r = 1'($urandom_range(0, 3) != 0);
            wa = s ? (($urandom_range(0, 7) == 0) ? 12'($urandom_range(1024, 4095)) : 12'($urandom_range(0, 1023)))
                   : 12'($urandom_range(0, 4095));
            ra = ($urandom_range(0, 1) == 0) ? wa
                 : (s ? 12'($urandom_range(0, 1100)) : 12'($urandom_range(0, 4095)));
            csel = s; cwr = w; crd = r; caddr_wr = wa; caddr_rd = ra; cdata_wr = 13'($urandom);
            exp_d = '0;
            if (r) exp_d = s ? ((ra < 12'd1024) ? l1_m[ra] : 13'd0) : l0_m[ra];
            @(negedge clk);
            chk("rand_cdata_rd", cdata_rd, exp_d);
            step();
            if (w && !s) l0_m[wa] = cdata_wr;
            if (w && s && wa < 12'd1024) l1_m[wa] = cdata_wr;
        end
        cwr = 1'b0; crd = 1'b0;
        @(negedge clk);
        chk("err_sticky", err, 1'b1);
        step();

        // Dump with out_ready toggling.
        busy = 1'b0;
        hs = 0; done_cnt = 0; bad_data = 0; bad_stable = 0; tail = 0;
        stall_pending = 1'b0; sel4097 = 1'b0; addr4097 = '1; held = '0;
        for (int c = 0; c < 12000; c++) begin
            out_ready = c[0];
            @(negedge clk);
            if (done) done_cnt++;
            if (out_valid) begin
                if (stall_pending && ({out_sel, out_addr, out_data} !== held)) bad_stable++;
                if (out_ready) begin
                    exp_d = (hs < 4096) ? l0_m[hs] : l1_m[hs - 4096];
                    if (out_sel !== (hs >= 4096) || out_addr !== 12'((hs < 4096) ? hs : hs - 4096)
                        || out_data !== exp_d) bad_data++;
                    if (hs == 4096) begin
                        sel4097 = out_sel;
                        addr4097 = out_addr;
                    end
                    hs++;
                    stall_pending = 1'b0;
                end else begin
                    held = {out_sel, out_addr, out_data};
                    stall_pending = 1'b1;
                end
            end
            step();
            if (done_cnt > 0) tail++;
            if (tail > 3) break;
        end
        out_ready = 1'b0;
        chk("dump_handshakes", hs, 5120);
        chk("dump_entry_mismatches", bad_data, 0);
        chk("dump_stall_unstable", bad_stable, 0);
        chk("dump_4097_sel", sel4097, 1'b1);
        chk("dump_4097_addr", addr4097, 12'd0);
        chk("done_pulses", done_cnt, 1);
        @(negedge clk);
        chk("idle_in_ready", in_ready, 1'b1);
        chk("idle_out_valid", out_valid, 1'b0);
        step();

        // Layer write outside RUN must be dropped.
        cwr = 1'b1; csel = 1'b0; caddr_wr = 12'd3; cdata_wr = ~l0_m[3];
        step();
        cwr = 1'b0; crd = 1'b1; caddr_rd = 12'd3;
        @(negedge clk);
        chk("cwr_outside_run", cdata_rd, l0_m[3]);
        iaddr = 12'h123;
        @(negedge clk);
        chk("image_retained", idata, 13'h0123);
        crd = 1'b0;
        step();

        // Second load with random data, then reset at dump entry 100.
        load_image(1'b0, bad);
        chk("load2_ready_low", bad, 0);
        busy = 1'b1;
        step();
        busy = 1'b0;
        out_ready = 1'b1;
        hit = 1'b0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (out_valid && out_addr == 12'd100) begin
                hit = 1'b1;
                break;
            end
            step();
        end
        chk("reached_entry_100", hit, 1'b1);
        chk("entry_100_data", out_data, l0_m[100]);
        reset = 1'b0;
        #1;
        chk("abort_out_valid", out_valid, 1'b0);
        chk("abort_done", done, 1'b0);
        step();
        step();
        reset = 1'b1;
        out_ready = 1'b0;
        step();
        @(negedge clk);
        chk("post_rst_in_ready", in_ready, 1'b1);
        chk("post_rst_ready", ready, 1'b0);
        chk("post_rst_out_valid", out_valid, 1'b0);
        chk("post_rst_err", err, 1'b0);
        for (int n = 0; n < 8; n++) begin
            iaddr = 12'($urandom_range(0, 4095));
            crd = 1'b1; csel = 1'($urandom_range(0, 1));
            caddr_rd = csel ? 12'($urandom_range(0, 1023)) : 12'($urandom_range(0, 4095));
            @(negedge clk);
            chk("post_rst_idata", idata, img_m[iaddr]);
            chk("post_rst_layer", cdata_rd, csel ? l1_m[caddr_rd] : l0_m[caddr_rd]);
        end
        crd = 1'b0;
        step();

        // Reset in the middle of a load.
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1; in_data = 13'($urandom); img_m[i] = in_data;
            step();
        end
        @(negedge clk);
        reset = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("load_abort_ready", ready, 1'b0);
        step();
        reset = 1'b1;
        step();
        @(negedge clk);
        chk("load_abort_in_ready", in_ready, 1'b1);
        iaddr = 12'd9;
        @(negedge clk);
        chk("load_abort_accepted_word", idata, img_m[9]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
